// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrates issue,
// registers the ALU operands and routes each result back to its owner.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [2:0]  i_req0_opsel,
  input  logic        i_req0_sub,
  input  logic        i_req0_unsigned,
  input  logic        i_req0_arith,
  input  logic [31:0] i_req0_op1,
  input  logic [31:0] i_req0_op2,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [2:0]  i_req1_opsel,
  input  logic        i_req1_sub,
  input  logic        i_req1_unsigned,
  input  logic        i_req1_arith,
  input  logic [31:0] i_req1_op1,
  input  logic [31:0] i_req1_op2,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_result,
  output logic        o_rsp0_eq,
  output logic        o_rsp0_slt,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_result,
  output logic        o_rsp1_eq,
  output logic        o_rsp1_slt,
  output logic [2:0]  o_alu_opsel,
  output logic        o_alu_sub,
  output logic        o_alu_unsigned,
  output logic        o_alu_arith,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_eq,
  input  logic        i_alu_slt
);

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  busy;
  logic [1:0]  rsp_valid;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic [31:0] rsp_result [2];
  logic [1:0]  rsp_eq;
  logic [1:0]  rsp_slt;

  logic        run_reg;
  logic        last_grant_reg;
  logic        issue_valid_reg;
  logic        owner_reg;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // run_reg blocks grants until the clock has sampled reset released once
  assign eligible = req_valid & ~busy & {2{run_reg}};

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = (FIXED_PRIO || last_grant_reg) ? 2'b01 : 2'b10;
    end
  end

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_reg         <= 1'b0;
      last_grant_reg  <= 1'b1;
      issue_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
      o_alu_opsel     <= 3'd0;
      o_alu_sub       <= 1'b0;
      o_alu_unsigned  <= 1'b0;
      o_alu_arith     <= 1'b0;
      o_alu_op1       <= 32'd0;
      o_alu_op2       <= 32'd0;
    end else begin
      run_reg         <= 1'b1;
      issue_valid_reg <= |grant;
      if (|grant) begin
        owner_reg      <= grant[1];
        last_grant_reg <= grant[1];
        o_alu_opsel    <= grant[1] ? i_req1_opsel    : i_req0_opsel;
        o_alu_sub      <= grant[1] ? i_req1_sub      : i_req0_sub;
        o_alu_unsigned <= grant[1] ? i_req1_unsigned : i_req0_unsigned;
        o_alu_arith    <= grant[1] ? i_req1_arith    : i_req0_arith;
        o_alu_op1      <= grant[1] ? i_req1_op1      : i_req0_op1;
        o_alu_op2      <= grant[1] ? i_req1_op2      : i_req0_op2;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic        busy_reg;
      logic        valid_reg;
      logic [31:0] result_reg;
      logic        eq_reg;
      logic        slt_reg;

      // Busy spans accept to response handshake, so a capture never lands on a full slot
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          busy_reg   <= 1'b0;
          valid_reg  <= 1'b0;
          result_reg <= 32'd0;
          eq_reg     <= 1'b0;
          slt_reg    <= 1'b0;
        end else begin
          if (grant[gi]) begin
            busy_reg <= 1'b1;
          end else if (valid_reg && rsp_ready[gi]) begin
            busy_reg <= 1'b0;
          end
          if (issue_valid_reg && (owner_reg == 1'(gi))) begin
            valid_reg  <= 1'b1;
            result_reg <= i_alu_result;
            eq_reg     <= i_alu_eq;
            slt_reg    <= i_alu_slt;
          end else if (valid_reg && rsp_ready[gi]) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign busy[gi]       = busy_reg;
      assign rsp_valid[gi]  = valid_reg;
      assign rsp_result[gi] = result_reg;
      assign rsp_eq[gi]     = eq_reg;
      assign rsp_slt[gi]    = slt_reg;
    end
  endgenerate

  assign o_rsp0_valid  = rsp_valid[0];
  assign o_rsp0_result = rsp_result[0];
  assign o_rsp0_eq     = rsp_eq[0];
  assign o_rsp0_slt    = rsp_slt[0];
  assign o_rsp1_valid  = rsp_valid[1];
  assign o_rsp1_result = rsp_result[1];
  assign o_rsp1_eq     = rsp_eq[1];
  assign o_rsp1_slt    = rsp_slt[1];

endmodule
